// File: rtl/echo_range_filter.sv
`default_nettype none
// ============================================================================
// Module  : echo_range_filter
// Purpose : echo width (cycles) -> clamped cm via restoring divide, then a
//           moving-average filter with a one-cycle valid strobe.
// Rev     : 1.0 - initial release
// ============================================================================
module echo_range_filter #(
   parameter int CYCLES_PER_CM = 2900,
   parameter int MAX_CM        = 400,
   parameter int AVG_LOG2      = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [20:0] echo_count,
   input  logic        count_valid,
   output logic [8:0]  cm,
   output logic        cm_valid,
   output logic        out_of_range,
   output logic        busy,
   output logic        overrun
);

   localparam int c_win    = 1 << AVG_LOG2;
   localparam int c_sum_w  = 9 + AVG_LOG2;
   localparam int c_fill_w = AVG_LOG2 + 1;

   localparam logic [22:0]         c_divisor   = 23'(CYCLES_PER_CM);
   localparam logic [20:0]         c_max_q     = 21'(MAX_CM);
   localparam logic [8:0]          c_max_cm    = 9'(MAX_CM);
   localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(c_win);
   localparam logic [c_fill_w-1:0] c_fill_one  = c_fill_w'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIVIDE = 2'd1,
      ST_FILTER = 2'd2,
      ST_EMIT   = 2'd3
   } state_t;

   state_t               state_q,     state_d;
   logic [20:0]          dividend_q,  dividend_d;
   logic [21:0]          rem_q,       rem_d;
   logic [20:0]          quot_q,      quot_d;
   logic [4:0]           bit_cnt_q,   bit_cnt_d;
   logic [8:0]           hist_q [c_win];
   logic [8:0]           hist_d [c_win];
   logic [c_fill_w-1:0]  fill_q,      fill_d;
   logic [c_sum_w-1:0]   sum_q,       sum_d;
   logic                 flag_q,      flag_d;
   logic [8:0]           cm_q,        cm_d;
   logic                 cm_valid_q,  cm_valid_d;
   logic                 oor_q,       oor_d;
   logic                 overrun_q,   overrun_d;

   logic [22:0]          w_trial;
   logic                 w_ge;
   logic                 w_over;
   logic [8:0]           w_sample;
   logic [8:0]           w_avg;

   // Datapath helpers: trial remainder for this quotient bit, clamp, average
   always_comb begin
      w_trial  = {rem_q, dividend_q[20]};
      w_ge     = (w_trial >= c_divisor);
      w_over   = (quot_q > c_max_q);
      w_sample = w_over ? c_max_cm : quot_q[8:0];
      w_avg    = 9'(sum_q >> AVG_LOG2);
   end

   always_comb begin
      state_d    = state_q;
      dividend_d = dividend_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      bit_cnt_d  = bit_cnt_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      sum_d      = sum_q;
      flag_d     = flag_q;
      cm_d       = cm_q;
      cm_valid_d = 1'b0;
      oor_d      = oor_q;
      overrun_d  = overrun_q;

      // A sample arriving mid-conversion is dropped, but remembered
      if (count_valid && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (count_valid) begin
               dividend_d = echo_count;
               rem_d      = '0;
               quot_d     = '0;
               bit_cnt_d  = 5'd20;
               state_d    = ST_DIVIDE;
            end
         end

         ST_DIVIDE: begin
            rem_d      = w_ge ? 22'(w_trial - c_divisor) : w_trial[21:0];
            quot_d     = {quot_q[19:0], w_ge};
            dividend_d = {dividend_q[19:0], 1'b0};
            if (bit_cnt_q == 5'd0) begin
               state_d = ST_FILTER;
            end else begin
               bit_cnt_d = bit_cnt_q - 5'd1;
            end
         end

         ST_FILTER: begin
            flag_d    = w_over;
            hist_d[0] = w_sample;
            for (int i = 1; i < c_win; i++) begin
               hist_d[i] = hist_q[i-1];
            end
            if (fill_q != c_fill_full) begin
               fill_d = fill_q + c_fill_one;
            end
            // Sum rebuilt from the new history so it cannot drift
            sum_d = '0;
            for (int i = 0; i < c_win; i++) begin
               sum_d = sum_d + c_sum_w'(hist_d[i]);
            end
            state_d = ST_EMIT;
         end

         ST_EMIT: begin
            cm_d       = (fill_q == c_fill_full) ? w_avg : hist_q[0];
            oor_d      = flag_q;
            cm_valid_d = 1'b1;
            state_d    = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         dividend_q <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         bit_cnt_q  <= '0;
         for (int i = 0; i < c_win; i++) begin
            hist_q[i] <= '0;
         end
         fill_q     <= '0;
         sum_q      <= '0;
         flag_q     <= 1'b0;
         cm_q       <= '0;
         cm_valid_q <= 1'b0;
         oor_q      <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         bit_cnt_q  <= bit_cnt_d;
         hist_q     <= hist_d;
         fill_q     <= fill_d;
         sum_q      <= sum_d;
         flag_q     <= flag_d;
         cm_q       <= cm_d;
         cm_valid_q <= cm_valid_d;
         oor_q      <= oor_d;
         overrun_q  <= overrun_d;
      end
   end

   assign cm           = cm_q;
   assign cm_valid     = cm_valid_q;
   assign out_of_range = oor_q;
   assign busy         = (state_q != ST_IDLE);
   assign overrun      = overrun_q;

endmodule
`default_nettype wire
